// File: rtl/sr_ctrl_pkg.sv
// Shared types and helpers for the sr_latch sequencer (sr_latch_ctrl) and its arbiter.
package sr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid            = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Shares one sr_latch among NUM_REQ requesters with safe s/r/en pulse sequencing.
// Optional readback checking of lat_q is enabled by defining SR_READBACK_CHECK_EN.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy,
  output logic               lat_s,
  output logic               lat_r,
  output logic               lat_en,
  output logic               lat_rst,
  input  logic               lat_q,
  output logic               state_q,
  output logic               err
);

  localparam int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  state_e             st_q, st_d;
  cnt_t               cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  idx_t               idx_q, idx_d;
  idx_t               ptr_q, ptr_d;
  logic               op_q, op_d;
  logic               shadow_q, shadow_d;
  logic               lat_s_q, lat_s_d;
  logic               lat_r_q, lat_r_d;
  logic               lat_en_q, lat_en_d;
  logic               lat_rst_q, lat_rst_d;
  logic               err_q, err_d;
  logic               ack_fire;

  logic [NUM_REQ-1:0] arb_onehot;
  idx_t               arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .valid      (arb_valid)
  );

  // The ACK state holds until its counter drains; the completion pulse is launched on that last cycle.
  assign ack_fire = (st_q == ST_ACK) && (cnt_q == '0);

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    shadow_d  = shadow_q;
    lat_s_d   = 1'b0;
    lat_r_d   = 1'b0;
    lat_en_d  = 1'b0;
    lat_rst_d = lat_rst_q;

    unique case (st_q)
      ST_INIT: begin
        // Hold the latch reset for one full cycle after rst_n is seen high.
        if (cnt_q == '0) begin
          cnt_d = cnt_t'(1);
        end else begin
          cnt_d     = '0;
          lat_rst_d = 1'b0;
          st_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (gnt_q != '0) begin
          gnt_d = '0;
        end else if (arb_valid) begin
          gnt_d = arb_onehot;
          idx_d = arb_idx;
          op_d  = op[arb_idx];
          if (op[arb_idx] == shadow_q) begin
            st_d  = ST_ACK;
            cnt_d = cnt_t'(1);
          end else begin
            st_d  = ST_DRIVE;
            cnt_d = cnt_t'(PULSE_CYC);
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - cnt_t'(1);
          lat_en_d = 1'b1;
          lat_s_d  = (op_q == OP_SET);
          lat_r_d  = (op_q == OP_CLR);
        end else begin
          st_d  = ST_SETTLE;
          cnt_d = cnt_t'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
        else             st_d  = ST_ACK;
      end
      ST_ACK: begin
        if (!ack_fire) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else begin
          ack_d    = gnt_q;
          shadow_d = op_q;
          ptr_d    = (idx_q == idx_t'(NUM_REQ - 1)) ? '0 : idx_q + idx_t'(1);
          st_d     = ST_IDLE;
        end
      end
      default: st_d = ST_INIT;
    endcase
  end

`ifdef SR_READBACK_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    err_d = err_q;
    mis_d = 1'b0;
    if (st_q == ST_IDLE && lat_q != shadow_q) begin
      mis_d = 1'b1;
      if (mis_q) err_d = 1'b1;
    end
    if (ack_fire && op_q != shadow_q && lat_q != op_q) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  logic unused_lat_q;

  assign unused_lat_q = lat_q;
  assign err_d        = 1'b0;
`endif

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= ST_INIT;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      op_q      <= 1'b0;
      shadow_q  <= 1'b0;
      lat_s_q   <= 1'b0;
      lat_r_q   <= 1'b0;
      lat_en_q  <= 1'b0;
      lat_rst_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      shadow_q  <= shadow_d;
      lat_s_q   <= lat_s_d;
      lat_r_q   <= lat_r_d;
      lat_en_q  <= lat_en_d;
      lat_rst_q <= lat_rst_d;
      err_q     <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign busy    = (st_q != ST_IDLE);
  assign lat_s   = lat_s_q;
  assign lat_r   = lat_r_q;
  assign lat_en  = lat_en_q;
  assign lat_rst = lat_rst_q;
  assign state_q = shadow_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: directed steps plus randomized transactions vs a behavioural model.
module tb_sr_latch_ctrl;

  localparam int N = 4;
  localparam int P = 2;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] op;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic         busy;
  logic         lat_s;
  logic         lat_r;
  logic         lat_en;
  logic         lat_rst;
  logic         lat_q;
  logic         state_q;
  logic         err;

  int   checks   = 0;
  int   failures = 0;
  int   ptr_m;
  logic shadow_m;
  logic err_exp  = 1'b0;
  logic latch_m  = 1'b0;
  bit   tie_zero = 1'b0;

  sr_latch_ctrl #(
    .NUM_REQ    (N),
    .PULSE_CYC  (P),
    .SETTLE_CYC (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy),
    .lat_s   (lat_s),
    .lat_r   (lat_r),
    .lat_en  (lat_en),
    .lat_rst (lat_rst),
    .lat_q   (lat_q),
    .state_q (state_q),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Behavioural sr_latch, sampled on the clock for simplicity.
  always @(posedge clk) begin
    if (lat_rst)               latch_m <= 1'b0;
    else if (lat_en && lat_s)  latch_m <= 1'b1;
    else if (lat_en && lat_r)  latch_m <= 1'b0;
  end
  assign lat_q = tie_zero ? 1'b0 : latch_m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_gnt"},     gnt, 0);
    check({pfx, "_ack"},     ack, 0);
    check({pfx, "_pins"},    {lat_s, lat_r, lat_en}, 0);
    check({pfx, "_lat_rst"}, lat_rst, 1);
    check({pfx, "_state_q"}, state_q, 0);
    check({pfx, "_err"},     err, 0);
    check({pfx, "_busy"},    busy, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();
    check("rst_release_lat_rst_hold", lat_rst, 1);
    check("rst_release_busy_hold", busy, 1);
    step();
    check("init_done_lat_rst", lat_rst, 0);
    check("init_done_busy", busy, 0);
    check("init_done_state_q", state_q, 0);
    check("init_done_gnt", gnt, 0);
    check("init_done_ack", ack, 0);
    check("init_done_err", err, 0);
    ptr_m    = 0;
    shadow_m = 1'b0;
  endtask

  task automatic do_txn(input logic [N-1:0] r, input logic [N-1:0] o, input int drop_at, input bit rel);
    int           g;
    int           lat;
    int           en_cnt;
    bit           got;
    bit           redundant;
    bit           settle_seen;
    logic         opb;
    logic         nopb;
    logic [N-1:0] g_oh;
    req = r;
    op  = o;
    g   = pick(r, ptr_m);
    g_oh    = '0;
    g_oh[g] = 1'b1;
    opb       = o[g];
    nopb      = ~opb;
    redundant = (opb === shadow_m);
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++) begin
      step();
      got = (gnt != '0);
    end
    check("grant_seen", got, 1);
    if (!got) return;
    check("grant_onehot", gnt, g_oh);
    check("busy_in_txn", busy, 1);
    lat         = -1;
    en_cnt      = 0;
    settle_seen = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (k == drop_at) req[g] = 1'b0;
      step();
      check("sr_exclusive", lat_s & lat_r, 0);
      if (lat_en) begin
        en_cnt++;
        check("pulse_s", lat_s, opb);
        check("pulse_r", lat_r, nopb);
      end else if (en_cnt > 0 && !settle_seen) begin
        settle_seen = 1'b1;
        check("settle_pins", {lat_s, lat_r, lat_en}, 0);
      end
      check("gnt_held", gnt, g_oh);
      if (ack != '0) lat = k;
    end
    check("ack_latency", lat, redundant ? 2 : (1 + P + S + 1));
    if (lat < 0) return;
    check("ack_target", ack, g_oh);
    check("shadow_at_ack", state_q, opb);
    check("err_at_ack", err, err_exp);
    check("en_cycles", en_cnt, redundant ? 0 : P);
    shadow_m = opb;
    ptr_m    = (g + 1) % N;
    if (rel) req = '0;
    step();
    check("ack_one_cycle", ack, 0);
    check("gap_gnt_low", gnt, 0);
    check("gap_busy_low", busy, 0);
  endtask

  initial begin
    bit           got;
    bit           seen;
    bit           settle;
    bit           ack_seen;
    logic [N-1:0] r;
    logic [N-1:0] o;
    rst_n = 1'b0;
    req   = '0;
    op    = '0;

    do_reset();

    // Single SET on requester 1, then a redundant SET on requester 2.
    do_txn(4'b0010, 4'b0010, 0, 1'b1);
    do_txn(4'b0100, 4'b0100, 0, 1'b1);

    // Fairness from pointer 0 with every requester active and mixed ops.
    do_reset();
    for (int t = 0; t < 5; t++) do_txn(4'b1111, 4'b0101, 0, 1'b0);
    req = '0;
    step();

    // Requester 3 drops its request during DRIVE; the transaction still completes.
    do_txn(4'b1000, {N{~shadow_m}}, 1, 1'b1);

    // Reset asserted during SETTLE aborts without an ack.
    req = 4'b0001;
    op  = {N{~shadow_m}};
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++) begin
      step();
      got = (gnt != '0);
    end
    check("rs_grant_seen", got, 1);
    seen   = 1'b0;
    settle = 1'b0;
    for (int w = 0; w < 12 && !settle; w++) begin
      step();
      if (lat_en) seen = 1'b1;
      else if (seen) settle = 1'b1;
    end
    check("rs_settle_reached", settle, 1);
    rst_n = 1'b0;
    step();
    check_reset_vals("rs_abort");
    rst_n    = 1'b1;
    req      = '0;
    ack_seen = 1'b0;
    for (int w = 0; w < 6; w++) begin
      step();
      if (ack != '0) ack_seen = 1'b1;
    end
    check("rs_no_ack", ack_seen, 0);
    ptr_m    = 0;
    shadow_m = 1'b0;

    // Readback tied low during a SET: err flags only when the checker is built in.
    do_reset();
    tie_zero = 1'b1;
`ifdef SR_READBACK_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    do_txn(4'b0001, 4'b1111, 0, 1'b1);
    step();
    check("err_sticky", err, err_exp);
    tie_zero = 1'b0;
    err_exp  = 1'b0;
    do_reset();

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      o = N'($urandom);
      do_txn(r, o, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
    end
    req = '0;
    step();
    check("final_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
